// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI master-side blocks.
//
//   Contents:
//     CSON / CSOFF        chip-select levels (active low)
//     state_t             frame-sequencer state encoding
//     IDLE/SETUP/SHIFT/HOLD  sequencer states
//     DEFAULT_FRAME_BITS  sclk periods per transaction (8 addr/RW + 8 data)
//     clog2_min1()        $clog2 that never returns 0, for counter widths
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam logic CSON  = 1'b0;
  localparam logic CSOFF = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t HOLD  = 2'd3;

  localparam int DEFAULT_FRAME_BITS = 16;

  // A counter that must hold values 0..n-1 needs at least one bit even
  // when n is 1, so clamp the width to 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sclk_divider.sv
// -----------------------------------------------------------------------------
// sclk_divider
//   Half-period counter that produces the SPI serial clock (CPOL=0) while
//   enabled. sclk stays low for DIV enabled cycles, then high for DIV cycles,
//   and so on. Disabling (or reset) clears the counter, forces sclk low and
//   drops both strobes, so the first half-period after enable is always a
//   full low phase.
//
//   Parameters:
//     DIV           sclk half-period in clk cycles (>= 1)
//
//   Ports:
//     clk           system clock, rising edge
//     reset         synchronous, active-high reset
//     en            run the divider; low clears it
//     sclk          registered serial clock
//     sclk_posedge  registered strobe, high in the first cycle sclk reads 1
//     sclk_negedge  registered strobe, high in the first cycle sclk reads 0
//                   after a high phase
//     fall_next     combinational look-ahead: the coming clk edge will take
//                   sclk from 1 to 0 (lets the sequencer react on the same
//                   edge as the falling edge itself)
// -----------------------------------------------------------------------------
module sclk_divider
  import spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic fall_next
);

  localparam int CW = clog2_min1(DIV);

  logic [CW-1:0] cnt_reg;
  logic          wrap;

  // With DIV=1 the counter is pinned at 0, so wrap is high every cycle and
  // sclk toggles on every enabled edge.
  assign wrap      = (cnt_reg == CW'(DIV - 1));
  assign fall_next = en && wrap && sclk;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_reg      <= '0;
      sclk         <= 1'b0;
      sclk_posedge <= 1'b0;
      sclk_negedge <= 1'b0;
    end else begin
      sclk_posedge <= 1'b0;
      sclk_negedge <= 1'b0;
      if (wrap) begin
        cnt_reg      <= '0;
        sclk         <= ~sclk;
        // Strobes are registered alongside the toggle, so each one is high
        // exactly in the cycle sclk first shows its new level.
        sclk_posedge <= ~sclk;
        sclk_negedge <= sclk;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
//   Master-side serial-clock and chip-select generator. A one-cycle start in
//   IDLE frames one transaction: cs goes low, FRAME_BITS sclk periods are
//   emitted, cs is released and done pulses. The sclk strobes feed the master
//   transaction FSM and shift registers.
//
//   Parameters:
//     DIV         sclk half-period in clk cycles (>= 1)
//     FRAME_BITS  sclk periods per transaction (>= 1)
//     CS_SETUP    cycles of cs low before the first sclk low phase (>= 1)
//     CS_HOLD     cycles of cs low after the last sclk fall (>= 1)
//
//   Ports:
//     clk           system clock, rising edge
//     reset         synchronous, active-high reset
//     start         transaction request, honoured only in IDLE
//     cs            chip select, active low
//     sclk          serial clock, idles low
//     sclk_posedge  one-cycle strobe on each sclk rise
//     sclk_negedge  one-cycle strobe on each sclk fall
//     bit_index     bit currently framed, 0 at frame start
//     busy          high for every cycle cs is low
//     done          one-cycle pulse in the first cycle cs is high again
//
//   Timeline (edge 0 samples start):
//     SETUP is entered at edge 0 but cs only drops at edge 1, because every
//     output is registered from the current state. SETUP therefore lasts
//     CS_SETUP+1 cycles, giving CS_SETUP cycles of cs low before the
//     divider's first low phase. The SHIFT->HOLD transition happens on the
//     same edge as the last sclk fall (via the divider look-ahead), and HOLD
//     counts CS_HOLD cycles before cs is released.
// -----------------------------------------------------------------------------
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  localparam int BIT_W     = clog2_min1(FRAME_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cs,
  output logic             sclk,
  output logic             sclk_posedge,
  output logic             sclk_negedge,
  output logic [BIT_W-1:0] bit_index,
  output logic             busy,
  output logic             done
);

  localparam int PHASE_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PW        = clog2_min1(PHASE_MAX + 1);

  state_t          state_reg;
  logic [PW-1:0]   phase_reg;
  logic            shift_en;
  logic            fall_next;

  assign shift_en = (state_reg == SHIFT);

  sclk_divider #(
    .DIV (DIV)
  ) u_sclk_divider (
    .clk          (clk),
    .reset        (reset),
    .en           (shift_en),
    .sclk         (sclk),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .fall_next    (fall_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      cs        <= CSOFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_index <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          cs        <= CSOFF;
          busy      <= 1'b0;
          bit_index <= '0;
          phase_reg <= '0;
          if (start) begin
            state_reg <= SETUP;
          end
        end

        SETUP: begin
          cs   <= CSON;
          busy <= 1'b1;
          if (phase_reg == PW'(CS_SETUP)) begin
            state_reg <= SHIFT;
            phase_reg <= '0;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end

        SHIFT: begin
          cs   <= CSON;
          busy <= 1'b1;
          if (fall_next) begin
            // The last fall ends the frame; bit_index parks on the final
            // bit until the frame is released.
            if (bit_index == BIT_W'(FRAME_BITS - 1)) begin
              state_reg <= HOLD;
              phase_reg <= '0;
            end else begin
              bit_index <= bit_index + 1'b1;
            end
          end
        end

        HOLD: begin
          if (phase_reg == PW'(CS_HOLD - 1)) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            cs        <= CSOFF;
            busy      <= 1'b0;
            done      <= 1'b1;
            bit_index <= '0;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          phase_reg <= '0;
          cs        <= CSOFF;
          busy      <= 1'b0;
          bit_index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_sclk_gen
//   Two instances share clk/reset: index 0 uses the default parameters,
//   index 1 uses DIV=1, FRAME_BITS=8, CS_SETUP=1, CS_HOLD=1. Whenever a start
//   is driven that the instance should accept, the bench pushes the expected
//   edge numbers of every cs fall/rise, strobe and done into per-instance
//   queues; a monitor on the falling clock edge pops and compares them as
//   the events appear. Any event with nothing queued is a spurious event.
// -----------------------------------------------------------------------------
module tb_spi_sclk_gen;
  import spi_pkg::*;

  localparam int DV [2] = '{4, 1};
  localparam int FB [2] = '{16, 8};
  localparam int SU [2] = '{2, 1};
  localparam int HO [2] = '{2, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_v [2];

  logic       cs_a, sclk_a, sp_a, sn_a, busy_a, done_a;
  logic [3:0] bi_a;
  logic       cs_b, sclk_b, sp_b, sn_b, busy_b, done_b;
  logic [2:0] bi_b;

  spi_sclk_gen dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .cs(cs_a), .sclk(sclk_a),
    .sclk_posedge(sp_a), .sclk_negedge(sn_a), .bit_index(bi_a),
    .busy(busy_a), .done(done_a)
  );

  spi_sclk_gen #(.DIV(1), .FRAME_BITS(8), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .cs(cs_b), .sclk(sclk_b),
    .sclk_posedge(sp_b), .sclk_negedge(sn_b), .bit_index(bi_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int q_fall [2][$];
  int q_rise [2][$];
  int q_pos  [2][$];
  int q_neg  [2][$];
  int q_idx  [2][$];
  int q_done [2][$];
  int free_at [2];

  logic prev_cs [2];
  logic prev_sclk [2];
  logic o_cs [2], o_sclk [2], o_sp [2], o_sn [2], o_busy [2], o_done [2];
  int   o_idx [2];

  task automatic chk(input string tag, input int d, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s dut%0d at edge %0d: observed %0d expected %0d", tag, d, cyc, obs, exp_v);
    end
  endtask

  function automatic int pop_q(input int kind, input int d);
    int v;
    v = -1;
    case (kind)
      0: if (q_fall[d].size() > 0) v = q_fall[d].pop_front();
      1: if (q_rise[d].size() > 0) v = q_rise[d].pop_front();
      2: if (q_pos[d].size()  > 0) v = q_pos[d].pop_front();
      3: if (q_neg[d].size()  > 0) v = q_neg[d].pop_front();
      4: if (q_idx[d].size()  > 0) v = q_idx[d].pop_front();
      default: if (q_done[d].size() > 0) v = q_done[d].pop_front();
    endcase
    return v;
  endfunction

  // Expected events for a frame whose start is sampled at edge e.
  function automatic void push_frame(input int d, input int e);
    int rise_e;
    int last_e;
    q_fall[d].push_back(e + 1);
    for (int k = 0; k < FB[d]; k++) begin
      rise_e = e + 1 + SU[d] + DV[d] + 2 * DV[d] * k;
      q_pos[d].push_back(rise_e);
      q_idx[d].push_back(k);
      q_neg[d].push_back(rise_e + DV[d]);
    end
    last_e = e + 1 + SU[d] + 2 * DV[d] * FB[d] + HO[d];
    q_rise[d].push_back(last_e);
    q_done[d].push_back(last_e);
    free_at[d] = last_e + 1;
  endfunction

  // Drop every expectation at or after edge r (abandoned by reset).
  function automatic void flush_from(input int d, input int r);
    while (q_fall[d].size() > 0 && q_fall[d][$] >= r) void'(q_fall[d].pop_back());
    while (q_rise[d].size() > 0 && q_rise[d][$] >= r) void'(q_rise[d].pop_back());
    while (q_neg[d].size()  > 0 && q_neg[d][$]  >= r) void'(q_neg[d].pop_back());
    while (q_done[d].size() > 0 && q_done[d][$] >= r) void'(q_done[d].pop_back());
    while (q_pos[d].size()  > 0 && q_pos[d][$]  >= r) begin
      void'(q_pos[d].pop_back());
      void'(q_idx[d].pop_back());
    end
  endfunction

  // Hold start high for n sampling edges; the model accepts it only in IDLE.
  task automatic drive_start(input int d, input int n);
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (cyc + 1 >= free_at[d]) push_frame(d, cyc + 1);
      @(posedge clk); #1;
    end
    start_v[d] = 1'b0;
  endtask

  task automatic wait_edge(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_bound", 0, int'(cyc >= t), 1);
  endtask

  // Reset sampled at the next edge r; any open frame is abandoned there.
  task automatic do_reset_mid();
    int  r;
    bit  act;
    @(posedge clk); #1;
    reset = 1'b1;
    r = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      act = (q_rise[d].size() > 0 && q_rise[d][$] >= r) &&
            !(q_fall[d].size() > 0 && q_fall[d][$] >= r);
      flush_from(d, r);
      if (act) q_rise[d].push_back(r);
      free_at[d] = r + 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_edge", 0, cyc, r);
    chk("rst_mid_cs",   0, int'(cs_a),   1);
    chk("rst_mid_sclk", 0, int'(sclk_a), 0);
    chk("rst_mid_busy", 0, int'(busy_a), 0);
    chk("rst_mid_done", 0, int'(done_a), 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    o_cs[0] = cs_a;     o_cs[1] = cs_b;
    o_sclk[0] = sclk_a; o_sclk[1] = sclk_b;
    o_sp[0] = sp_a;     o_sp[1] = sp_b;
    o_sn[0] = sn_a;     o_sn[1] = sn_b;
    o_busy[0] = busy_a; o_busy[1] = busy_b;
    o_done[0] = done_a; o_done[1] = done_b;
    o_idx[0] = int'(bi_a);
    o_idx[1] = int'(bi_b);
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy_vs_cs", d, int'(o_busy[d]), int'(o_cs[d] === CSON));
        if (o_cs[d] === CSOFF) chk("sclk_low_cs_high", d, int'(o_sclk[d]), 0);
        if (o_cs[d] === CSON && prev_cs[d] === CSOFF) begin
          chk("cs_fall_edge", d, cyc, pop_q(0, d));
          chk("idx_at_fall", d, o_idx[d], 0);
        end
        if (o_cs[d] === CSOFF && prev_cs[d] === CSON)
          chk("cs_rise_edge", d, cyc, pop_q(1, d));
        if (o_sp[d] === 1'b1) begin
          chk("posedge_edge", d, cyc, pop_q(2, d));
          chk("posedge_idx", d, o_idx[d], pop_q(4, d));
          chk("posedge_on_rise", d, int'({prev_sclk[d], o_sclk[d]}), 1);
        end
        if (o_sn[d] === 1'b1) begin
          chk("negedge_edge", d, cyc, pop_q(3, d));
          chk("negedge_on_fall", d, int'({prev_sclk[d], o_sclk[d]}), 2);
        end
        if (o_done[d] === 1'b1) begin
          chk("done_edge", d, cyc, pop_q(5, d));
          chk("done_cs_high", d, int'(o_cs[d]), 1);
          chk("done_idx", d, o_idx[d], 0);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      prev_cs[d]   = o_cs[d];
      prev_sclk[d] = o_sclk[d];
    end
  end

  initial begin
    int t0;
    int last;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    prev_cs[0] = 1'b1;   prev_cs[1] = 1'b1;
    prev_sclk[0] = 1'b0; prev_sclk[1] = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    free_at[0] = cyc + 1;
    free_at[1] = cyc + 1;

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_cs",   0, int'(cs_a), 1);
    chk("rst_sclk", 0, int'(sclk_a), 0);
    chk("rst_pos",  0, int'(sp_a), 0);
    chk("rst_neg",  0, int'(sn_a), 0);
    chk("rst_busy", 0, int'(busy_a), 0);
    chk("rst_done", 0, int'(done_a), 0);
    chk("rst_idx",  0, int'(bi_a), 0);
    chk("rst_cs",   1, int'(cs_b), 1);
    chk("rst_sclk", 1, int'(sclk_b), 0);
    chk("rst_busy", 1, int'(busy_b), 0);
    chk("rst_idx",  1, int'(bi_b), 0);

    // Single frame, default parameters.
    drive_start(0, 1);
    wait_edge(free_at[0] + 2);

    // start held high: back-to-back frames with a 2-cycle cs-high gap.
    drive_start(0, 300);
    wait_edge(free_at[0] + 2);

    // A second pulse 50 edges into a frame must be ignored.
    t0 = cyc + 2;
    drive_start(0, 1);
    wait_edge(t0 + 48);
    drive_start(0, 1);
    wait_edge(free_at[0] + 2);

    // Reset in the middle of a frame, then a fresh nominal frame.
    t0 = cyc + 2;
    drive_start(0, 1);
    wait_edge(t0 + 59);
    do_reset_mid();
    drive_start(0, 1);
    wait_edge(free_at[0] + 2);

    // Fast configuration: single frame and held start.
    drive_start(1, 1);
    wait_edge(free_at[1] + 2);
    drive_start(1, 45);
    wait_edge(free_at[1] + 2);

    // Random spacing of start requests on both instances.
    for (int i = 0; i < 10; i++) begin
      int d;
      d = $urandom_range(0, 1);
      repeat ($urandom_range(0, 150)) @(posedge clk);
      drive_start(d, $urandom_range(1, 3));
    end
    last = (free_at[0] > free_at[1]) ? free_at[0] : free_at[1];
    wait_edge(last + 3);

    for (int d = 0; d < 2; d++) begin
      chk("left_fall", d, q_fall[d].size(), 0);
      chk("left_rise", d, q_rise[d].size(), 0);
      chk("left_pos",  d, q_pos[d].size(),  0);
      chk("left_neg",  d, q_neg[d].size(),  0);
      chk("left_done", d, q_done[d].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
